// File: rtl/bht_pkg.sv
// Shared branch-history-table helpers: counter reset value, saturating next state,
// taken threshold and the PC word-offset used to slice the table index.
package bht_pkg;

    localparam int CNT_MAX_W     = 4;
    localparam int PC_WORD_SHIFT = 2;

    typedef logic [CNT_MAX_W-1:0] cnt_t;

    // Weakly-not-taken: one below the taken threshold.
    function automatic cnt_t cnt_reset_val(input int cnt_w);
        return cnt_t'((1 << (cnt_w - 1)) - 1);
    endfunction

    function automatic cnt_t cnt_next(input cnt_t cur, input logic taken, input int cnt_w);
        cnt_t max_v;
        cnt_t nxt;
        max_v = cnt_t'((1 << cnt_w) - 1);
        nxt   = cur;
        if (taken) begin
            if (cur != max_v) nxt = cur + cnt_t'(1);
        end else begin
            if (cur != '0) nxt = cur - cnt_t'(1);
        end
        return nxt;
    endfunction

    function automatic logic cnt_is_taken(input cnt_t cur, input int cnt_w);
        cnt_t sh;
        sh = cur >> (cnt_w - 1);
        return sh[0];
    endfunction

endpackage

// File: rtl/bht_counter_update.sv
// Combinational saturating counter next state; feeds both the table write and the read bypass.
module bht_counter_update
    import bht_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             taken_i,
    output logic [CNT_W-1:0] cnt_o
);

    assign cnt_o = CNT_W'(cnt_next(cnt_t'(cnt_i), taken_i, CNT_W));

endmodule

// File: rtl/bht_predictor.sv
// Direct-mapped BHT of saturating counters, 1-cycle registered prediction, write-first bypass.
// Optional gshare index hashing with a global history register when BHT_GSHARE_EN is defined.
module bht_predictor
    import bht_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 5,
    parameter int CNT_W  = 2,
    parameter int HIST_W = IDX_W
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              en,
    input  logic              read_valid,
    input  logic [ADDR_W-1:0] read_addr,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [IDX_W-1:0]  pred_index,
    input  logic              update_valid,
    input  logic [IDX_W-1:0]  update_index,
    input  logic              update_taken
);

    localparam int                DEPTH   = 1 << IDX_W;
    localparam logic [CNT_W-1:0]  CNT_RST = CNT_W'(cnt_reset_val(CNT_W));

    logic [CNT_W-1:0] cnt_q [DEPTH];

    logic             rd_acc;
    logic             upd_acc;
    logic [IDX_W-1:0] base_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [CNT_W-1:0] upd_cur;
    logic [CNT_W-1:0] upd_nxt;
    logic [CNT_W-1:0] rd_cnt;

    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic [IDX_W-1:0] pred_index_q, pred_index_d;

    // Offset bits and PC bits above the index do not participate in the lookup.
    logic unused_addr;
    assign unused_addr = ^{read_addr[ADDR_W-1:IDX_W+PC_WORD_SHIFT], read_addr[PC_WORD_SHIFT-1:0]};

    assign rd_acc   = en && read_valid;
    assign upd_acc  = en && update_valid;
    assign base_idx = read_addr[IDX_W+PC_WORD_SHIFT-1:PC_WORD_SHIFT];

`ifdef BHT_GSHARE_EN
    logic [HIST_W-1:0] hist_q, hist_d;

    // Reads see the pre-shift history even when an update lands in the same cycle.
    assign rd_idx = base_idx ^ IDX_W'(hist_q);
    assign hist_d = upd_acc ? HIST_W'({hist_q, update_taken}) : hist_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) hist_q <= '0;
        else      hist_q <= hist_d;
    end
`else
    assign rd_idx = base_idx;
`endif

    assign upd_cur = cnt_q[update_index];

    bht_counter_update #(.CNT_W(CNT_W)) u_cnt_upd (
        .cnt_i   (upd_cur),
        .taken_i (update_taken),
        .cnt_o   (upd_nxt)
    );

    assign rd_cnt = (upd_acc && (update_index == rd_idx)) ? upd_nxt : cnt_q[rd_idx];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_RST;
        end else if (upd_acc) begin
            cnt_q[update_index] <= upd_nxt;
        end
    end

    always_comb begin
        pred_valid_d = rd_acc;
        pred_taken_d = pred_taken_q;
        pred_index_d = pred_index_q;
        if (rd_acc) begin
            pred_taken_d = cnt_is_taken(cnt_t'(rd_cnt), CNT_W);
            pred_index_d = rd_idx;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_index_q <= '0;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_index_q <= pred_index_d;
        end
    end

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_index = pred_index_q;

endmodule
